// File: rtl/sysid_checker.sv
// Reads the two-word system-ID slave, compares ID (and optionally timestamp) against
// build-time constants, retries on mismatch or stall timeout, and holds a sticky verdict.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd896765832,
    parameter logic [31:0] EXPECTED_TS    = 32'd1309468710,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout_err,
    output logic [3:0]  retry_count
);

    typedef enum logic [2:0] {
        BOOT, IDLE, RD_ID, GAP, RD_TS, EVAL, RETRY, FIN
    } state_t;

    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

    state_t      state, state_nx;
    logic [15:0] stall_cnt;
    logic        rd_state, accept, tmo, match, can_retry, run_entry;

    assign rd_state  = (state == RD_ID) || (state == RD_TS);
    assign accept    = rd_state && !avm_waitrequest;
    // Fires on the last permitted stall cycle so avm_read is high for exactly TIMEOUT_CYCLES stalls.
    assign tmo       = rd_state && avm_waitrequest && (stall_cnt == STALL_LAST);
    assign match     = (id_value == EXPECTED_ID) && (!CHECK_TS || ts_value == EXPECTED_TS);
    assign can_retry = retry_count < RETRY_MAX;
    assign run_entry = (state == BOOT) || (state == IDLE && start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = RD_ID;
            IDLE:    if (start) state_nx = RD_ID;
            RD_ID:   if (accept) state_nx = GAP;
                     else if (tmo) state_nx = RETRY;
            GAP:     state_nx = RD_TS;
            RD_TS:   if (accept) state_nx = EVAL;
                     else if (tmo) state_nx = RETRY;
            EVAL:    state_nx = match ? FIN : RETRY;
            RETRY:   state_nx = can_retry ? RD_ID : FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = BOOT;
        endcase
    end

    always_comb begin
        avm_read    = rd_state;
        avm_address = (state == RD_TS);
    end

    // Every read state is entered from a non-read state, so clearing outside them suffices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           stall_cnt <= '0;
        else if (!rd_state)                  stall_cnt <= '0;
        else if (avm_waitrequest)            stall_cnt <= stall_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_value    <= '0;
            ts_value    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
            retry_count <= '0;
        end else begin
            if (accept && state == RD_ID) id_value <= avm_readdata;
            if (accept && state == RD_TS) ts_value <= avm_readdata;
            if (run_entry) begin
                busy        <= 1'b1;
                done        <= 1'b0;
                pass        <= 1'b0;
                fail        <= 1'b0;
                timeout_err <= 1'b0;
                retry_count <= '0;
            end else begin
                if (tmo) timeout_err <= 1'b1;
                if (state == EVAL && match) pass <= 1'b1;
                if (state == RETRY) begin
                    if (can_retry) retry_count <= retry_count + 4'd1;
                    else           fail        <= 1'b1;
                end
                if (state == FIN) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM master that sequences reads of the 2-word system-ID slave: word 0 = system ID, word 1 = build timestamp.
- Compares both words against build-time expected values, retries on mismatch or timeout, and publishes a sticky pass/fail status.
- Sits between the system-ID slave and the board status/LED logic, so a wrong FPGA image is flagged before host software runs.

Parameters:
- EXPECTED_ID, 32'd896765832, value required at address 0.
- EXPECTED_TS, 32'd1309468710, value required at address 1.
- CHECK_TS, 1, 1 = timestamp must also match; 0 = word 1 is captured only.
- TIMEOUT_CYCLES, 255, max cycles a read may stay stalled by waitrequest (1..65535).
- MAX_RETRIES, 3, extra full sequences after the first failed one (0..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: re-run check; ignored while busy
- avm_address  out  1  word select to the sysid slave
- avm_read  out  1  read strobe
- avm_readdata  in  32  read data, valid when avm_read=1 and avm_waitrequest=0
- avm_waitrequest  in  1  slave stall
- id_value  out  32  last captured word 0
- ts_value  out  32  last captured word 1
- busy  out  1  sequence in progress
- done  out  1  sticky: sequence finished
- pass  out  1  sticky: final result matched
- fail  out  1  sticky: retries exhausted with mismatch or timeout
- timeout_err  out  1  sticky: at least one read timed out during the current run
- retry_count  out  4  retries consumed in the current run

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM = BOOT.
- States and transitions:
  - BOOT: 1 cycle, -> RD_ID. Auto-check after every reset.
  - IDLE: start=1 -> RD_ID.
  - RD_ID: avm_read=1, avm_address=0.
  - RD_TS: avm_read=1, avm_address=1.
  - EVAL: 1 cycle.
  - RETRY: 1 cycle.
  - FIN: 1 cycle.
- Run entry (leaving IDLE/BOOT): clear done, pass, fail, timeout_err, retry_count; busy=1 from the first RD_ID cycle.
- Read accept: a read completes in the cycle avm_read=1 and avm_waitrequest=0.
  - Data is captured into id_value/ts_value on that edge.
  - RD_ID -> RD_TS; RD_TS -> EVAL.
  - Zero-wait slave: RD_ID and RD_TS last 1 cycle each.
- avm_read is deasserted for exactly one cycle between RD_ID and RD_TS, and in all other states.
  - Implement RD_ID -> GAP -> RD_TS; GAP is 1 cycle.
  - Zero-wait latency: start high in cycle 0 -> done=1 visible in cycle 6 (RD_ID 1, GAP 2, RD_TS 3, EVAL 4, FIN 5, outputs registered 6).
- avm_address and avm_read are stable while waitrequest is high.
- Timeout: a 16-bit stall counter clears on entry to each read state and increments every cycle waitrequest=1.
  - On reaching TIMEOUT_CYCLES with waitrequest still 1: drop avm_read, set timeout_err, -> RETRY.
  - A timed-out word does not update its capture register.
- EVAL: match = (id_value == EXPECTED_ID) && (!CHECK_TS || ts_value == EXPECTED_TS).
  - match -> FIN with pass=1.
  - else -> RETRY.
- RETRY:
  - retry_count < MAX_RETRIES: increment, -> RD_ID.
  - else: -> FIN with fail=1.
- FIN: done=1, busy=0, -> IDLE. pass and fail are never both 1.
- start while busy: ignored, not queued.
- start in the same cycle FIN -> IDLE: ignored; start is accepted only in IDLE.
- retry_count saturates at MAX_RETRIES and never wraps.
- Reset mid-read: avm_read drops immediately (async); the sequence restarts via BOOT after release.

Test Plan:
- Zero-wait slave returning 896765832 / 1309468710, reset released -> reads addr 0 then addr 1; pass=1, done=1, fail=0, retry_count=0; done asserted 6 cycles after BOOT exit.
- Slave returns 0x12345678 at addr 0 always, MAX_RETRIES=3 -> exactly 4 read pairs; retry_count=3, fail=1, pass=0, id_value=0x12345678.
- CHECK_TS=0, wrong timestamp 0xDEADBEEF -> pass=1, ts_value=0xDEADBEEF.
- waitrequest held high 300 cycles on addr 1, TIMEOUT_CYCLES=255 -> avm_read drops after 255 stall cycles, timeout_err=1, retry issued; if the slave then behaves, pass=1 with timeout_err still 1.
- Wrong ID for the first 2 runs, then correct -> pass=1, retry_count=2; then pulse start in IDLE -> status clears and a new run passes with retry_count=0.
- Assert reset during a 10-cycle waitrequest stall in RD_TS -> avm_read=0 immediately, all status 0; after release a full run restarts at addr 0; start pulses while busy have no effect.
